// File: rtl/rr_arbiter_8_v.sv
// 8-requester round-robin arbiter with registered one-hot grant, held until release.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant active; pick the next winner from the rotating pointer
// GRANT | one requester owns the resource until done, withdraw or timeout
module rr_arbiter_8_v
`ifdef ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = 16
)
`endif
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_req,
    input  logic       i_done,
    output logic [7:0] o_gnt,
    output logic [2:0] o_gnt_id,
    output logic       o_gnt_v,
    output logic       o_timeout
);

    localparam int N = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] ptr;
    logic [2:0] ptr_nxt;
    logic [7:0] gnt_nxt;
    logic [2:0] gnt_id_nxt;
    logic       gnt_v_nxt;

    logic       req_any;
    logic [2:0] winner;
    logic       release_norm;
    logic       release_force;

    assign req_any      = |i_req;
    assign release_norm = i_done | ~i_req[o_gnt_id];

    // Rotated priority scan: lowest index at or above ptr wins, wrapping past 7.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < N; k++) begin
            idx = ptr + 3'(k);
            if (!found && i_req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_nxt;
    logic       timeout_nxt;

    assign release_force = (hold_cnt == 8'(MAX_HOLD - 1));
`else
    assign release_force = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_nxt    = o_gnt;
        gnt_id_nxt = o_gnt_id;
        gnt_v_nxt  = o_gnt_v;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_nxt = hold_cnt;
        timeout_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt  = GRANT;
                    gnt_nxt    = 8'b1 << winner;
                    gnt_id_nxt = winner;
                    gnt_v_nxt  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_nxt = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (release_norm || release_force) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 8'd0;
                    gnt_v_nxt = 1'b0;
                    ptr_nxt   = o_gnt_id + 3'd1;
`ifdef ARB_TIMEOUT_EN
                    // A normal release in the same cycle is not reported as a timeout.
                    timeout_nxt = ~release_norm;
`endif
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 8'd0;
                gnt_v_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            o_gnt    <= 8'd0;
            o_gnt_id <= 3'd0;
            o_gnt_v  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            o_gnt    <= gnt_nxt;
            o_gnt_id <= gnt_id_nxt;
            o_gnt_v  <= gnt_v_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_cnt  <= 8'd0;
            o_timeout <= 1'b0;
        end else begin
            hold_cnt  <= hold_cnt_nxt;
            o_timeout <= timeout_nxt;
        end
    end
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8_v.sv
// Bench for rr_arbiter_8_v: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model of the round-robin rules.
module tb_rr_arbiter_8_v;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = 8'd0;
    logic       done  = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_v;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int HOLD = 16;

    // reference model state
    int m_ptr  = 0;
    bit m_busy = 1'b0;
    int m_id   = 0;
    int m_hold = 0;
    bit m_to   = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter_8_v dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_done    (done),
        .o_gnt     (gnt),
        .o_gnt_id  (gnt_id),
        .o_gnt_v   (gnt_v),
        .o_timeout (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = 1'b0;
        m_id   = 0;
        m_hold = 0;
        m_to   = 1'b0;
    endtask

    // One clock edge of the arbitration rules, using the inputs seen at the edge.
    task automatic model_edge();
        bit rel;
        m_to = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < 8; k++) begin
                if (!m_busy && req[(m_ptr + k) % 8]) begin
                    m_busy = 1'b1;
                    m_id   = (m_ptr + k) % 8;
                    m_hold = 0;
                end
            end
        end else begin
            rel = done || !req[m_id];
            if (!rel && TO_EN && m_hold == HOLD - 1) begin
                rel  = 1'b1;
                m_to = 1'b1;
            end
            if (rel) begin
                m_busy = 1'b0;
                m_ptr  = (m_id + 1) % 8;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_v"},   32'(gnt_v), 32'(m_busy));
        check({tag, "_gnt"}, 32'(gnt), m_busy ? (32'd1 << m_id) : 32'd0);
        if (m_busy) check({tag, "_id"}, 32'(gnt_id), 32'(m_id));
        check({tag, "_to"},  32'(timeout), 32'(m_to));
        check({tag, "_onehot"}, 32'($countones(gnt) <= 1), 32'd1);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    initial begin
        int drop_at;
        logic to16;
        logic to17;

        #2;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_v",   32'(gnt_v), 32'd0);
        check("rst_to",  32'(timeout), 32'd0);
        #10;
        rst_n = 1'b1;
        model_reset();

        // rotation through all requesters with one idle cycle between grants
        req = 8'hFF;
        for (int k = 0; k <= 8; k++) begin
            step("rot");
            check("rot_id", 32'(gnt_id), 32'(k % 8));
            done = 1'b1;
            step("rot_rel");
            check("rot_gap", 32'(gnt_v), 32'd0);
            done = 1'b0;
        end

        // pointer wrap: ptr=6 with req 0x05 picks 0, then ptr=1 picks 2
        req = 8'h20;
        step("wrap_g5");
        check("wrap_id5", 32'(gnt_id), 32'd5);
        done = 1'b1;
        step("wrap_r5");
        done = 1'b0;
        req  = 8'h05;
        step("wrap_g0");
        check("wrap_id0", 32'(gnt_id), 32'd0);
        done = 1'b1;
        step("wrap_r0");
        done = 1'b0;
        step("wrap_g2");
        check("wrap_id2", 32'(gnt_id), 32'd2);
        done = 1'b1;
        step("wrap_r2");
        done = 1'b0;

        // withdraw releases and advances ptr past the grantee
        req = 8'h08;
        step("wd_g3");
        check("wd_id3", 32'(gnt_id), 32'd3);
        req = 8'h00;
        step("wd_drop");
        check("wd_gnt0", 32'(gnt), 32'd0);
        req = 8'h18;
        step("wd_g4");
        check("wd_id4", 32'(gnt_id), 32'd4);
        done = 1'b1;
        step("wd_r4");
        done = 1'b0;

        // grantee re-requesting in its release cycle loses
        req = 8'h04;
        step("rr_g2");
        check("rr_id2", 32'(gnt_id), 32'd2);
        req  = 8'h84;
        done = 1'b1;
        step("rr_rel");
        done = 1'b0;
        step("rr_g7");
        check("rr_id7", 32'(gnt_id), 32'd7);

        // async reset mid-grant
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_gnt", 32'(gnt), 32'd0);
        check("mrst_v",   32'(gnt_v), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h81;
        step("mrst_g");
        check("mrst_id0", 32'(gnt_id), 32'd0);

        // done together with withdraw is a single release
        req  = 8'h00;
        done = 1'b1;
        step("both_rel");
        done = 1'b0;
        req  = 8'h83;
        step("both_g");
        check("both_id1", 32'(gnt_id), 32'd1);
        done = 1'b1;
        step("both_r");
        done = 1'b0;

        // long hold: forced release with the timeout build, held forever without
        req = 8'h10;
        step("hold_g");
        drop_at = -1;
        to16    = 1'b0;
        to17    = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            step("hold");
            if (drop_at < 0 && !gnt_v) drop_at = i;
            if (i == 16) to16 = timeout;
            if (i == 17) to17 = timeout;
        end
        check("hold_drop_at", 32'(drop_at), TO_EN ? 32'd16 : 32'hFFFF_FFFF);
        check("hold_to_pulse", 32'(to16), 32'(TO_EN));
        check("hold_to_once", 32'(to17), 32'd0);
        check("hold_v100", 32'(gnt_v), 32'd1);
        req = 8'h00;
        step("hold_rel");

        // random traffic with occasional async reset
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if (req[b]) begin
                    if ($urandom_range(0, 7) == 0) req[b] = 1'b0;
                end else begin
                    if ($urandom_range(0, 3) == 0) req[b] = 1'b1;
                end
            end
            done = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rnd_rst_gnt", 32'(gnt), 32'd0);
                check("rnd_rst_v", 32'(gnt_v), 32'd0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
